// File: rtl/mc_dp_pkg.sv
// Shared encodings for the handshaked multicycle datapath.
package mc_dp_pkg;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'd0,
        PCSRC_ALUOUT = 2'd1,
        PCSRC_JMP    = 2'd2,
        PCSRC_RSVD   = 2'd3
    } pc_src_e;

    typedef enum logic [1:0] {
        SRCB_B      = 2'd0,
        SRCB_FOUR   = 2'd1,
        SRCB_IMM    = 2'd2,
        SRCB_IMM_SH = 2'd3
    } alusrcb_e;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

    // ALU operation encoding shared with the controller
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mem_handshake.sv
// Memory req/ready sequencer: owns request, stall, wait counter and timeout.
module mem_handshake
    import mc_dp_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic mem_step,
    input  logic mem_ready,
    output logic mem_req,
    output logic stall,
    output logic done,
    output logic timeout
);

    localparam int CW = $clog2(MAX_WAIT + 2);
    localparam logic [CW-1:0] CNT_SAT = CW'(MAX_WAIT + 1);
    localparam logic [CW-1:0] CNT_LIM = CW'(MAX_WAIT);

    mem_state_e    state, state_nx;
    logic [CW-1:0] cnt;

    // Next state and request/stall decode; reset forces the request off
    always_comb begin
        state_nx = state;
        mem_req  = 1'b0;
        stall    = 1'b0;
        if (!reset) begin
            case (state)
                MEM_IDLE: begin
                    if (mem_step) begin
                        mem_req = 1'b1;
                        if (!mem_ready) begin
                            stall    = 1'b1;
                            state_nx = MEM_WAIT;
                        end
                    end
                end
                MEM_WAIT: begin
                    mem_req = 1'b1;
                    stall   = !mem_ready;
                    if (mem_ready) state_nx = MEM_IDLE;
                end
                default: state_nx = MEM_IDLE;
            endcase
        end
    end

    assign done = mem_req & mem_ready;

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (reset) state <= MEM_IDLE;
        else       state <= state_nx;
    end

    // Count stalled cycles of a request; sticky timeout once the count passes MAX_WAIT
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            timeout <= 1'b0;
        end else if (stall) begin
            if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
            if (cnt >= CNT_LIM) timeout <= 1'b1;
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/mc_datapath_hs.sv
// Parametrised multicycle MIPS datapath with a stalling memory handshake.
module mc_datapath_hs
    import mc_dp_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREG     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              MAX_WAIT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mem_step,
    input  logic            mem_write,
    input  logic            i_or_d,
    input  logic            ireg_enab,
    input  logic            pc_enab,
    input  logic [1:0]      pc_src,
    input  logic            alu_srcA,
    input  logic [1:0]      alu_srcB,
    input  logic            reg_dst,
    input  logic            mem_to_reg,
    input  logic            reg_write,
    input  logic [2:0]      alu_ctrl_sig,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            mem_req,
    output logic            mem_we,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    output logic            stall,
    output logic            timeout,
    output logic            zero,
    output logic [31:0]     inst
);

    localparam int RW = $clog2(NREG);

    logic [XLEN-1:0] pc, data_reg, a_reg, b_reg, alu_out;
    logic [XLEN-1:0] src_a, src_b, alu_res, imm_se, jmp_tgt, pc_nx, wb_data, rd_a, rd_b;
    logic [XLEN-1:0] rf [NREG];
    logic [RW-1:0]   rs, rt, rd, wr_idx;
    logic            done;

    mem_handshake #(.MAX_WAIT(MAX_WAIT)) u_hs (
        .clk      (clk),
        .reset    (reset),
        .mem_step (mem_step),
        .mem_ready(mem_ready),
        .mem_req  (mem_req),
        .stall    (stall),
        .done     (done),
        .timeout  (timeout)
    );

    assign rs      = inst[21 +: RW];
    assign rt      = inst[16 +: RW];
    assign rd      = inst[11 +: RW];
    assign wr_idx  = reg_dst ? rd : rt;
    assign wb_data = mem_to_reg ? data_reg : alu_out;
    assign rd_a    = (rs == '0) ? '0 : rf[rs];
    assign rd_b    = (rt == '0) ? '0 : rf[rt];
    assign imm_se  = {{(XLEN-16){inst[15]}}, inst[15:0]};
    assign jmp_tgt = {pc[XLEN-1:28], inst[25:0], 2'b00};

    // Address and store data come from registers frozen during a stall
    assign mem_addr  = i_or_d ? alu_out : pc;
    assign mem_wdata = b_reg;
    assign mem_we    = mem_write & mem_req;
    assign zero      = (alu_res == '0);
    assign src_a     = alu_srcA ? a_reg : pc;

    // ALU B operand select
    always_comb begin
        src_b = b_reg;
        case (alu_srcB)
            SRCB_B:      src_b = b_reg;
            SRCB_FOUR:   src_b = XLEN'(4);
            SRCB_IMM:    src_b = imm_se;
            SRCB_IMM_SH: src_b = {imm_se[XLEN-3:0], 2'b00};
            default:     src_b = b_reg;
        endcase
    end

    // ALU, wrapping arithmetic
    always_comb begin
        alu_res = '0;
        case (alu_ctrl_sig)
            ALU_AND: alu_res = src_a & src_b;
            ALU_OR:  alu_res = src_a | src_b;
            ALU_ADD: alu_res = src_a + src_b;
            ALU_SUB: alu_res = src_a - src_b;
            ALU_SLT: alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            default: alu_res = '0;
        endcase
    end

    // PC source select; the reserved code holds the PC
    always_comb begin
        pc_nx = pc;
        case (pc_src)
            PCSRC_ALU:    pc_nx = alu_res;
            PCSRC_ALUOUT: pc_nx = alu_out;
            PCSRC_JMP:    pc_nx = jmp_tgt;
            default:      pc_nx = pc;
        endcase
    end

    // Architectural registers; everything but load capture freezes while stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            inst     <= '0;
            data_reg <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            alu_out  <= '0;
        end else begin
            if (pc_enab && !stall) pc <= pc_nx;
            if (done && !mem_write) begin
                data_reg <= mem_rdata;
                if (ireg_enab) inst <= mem_rdata[31:0];
            end
            if (!stall) begin
                a_reg   <= rd_a;
                b_reg   <= rd_b;
                alu_out <= alu_res;
            end
        end
    end

    // Register file write; register 0 stays zero, contents are not reset
    always_ff @(posedge clk) begin
        if (reg_write && !stall && (wr_idx != '0)) rf[wr_idx] <= wb_data;
    end

endmodule

// File: tb/tb_mc_datapath_hs.sv
// Directed bench for mc_datapath_hs with a request scoreboard.
module tb_mc_datapath_hs;
    import mc_dp_pkg::*;

    logic        clk = 1'b0;
    logic        reset, mem_step, mem_write, i_or_d, ireg_enab, pc_enab;
    logic [1:0]  pc_src, alu_srcB;
    logic        alu_srcA, reg_dst, mem_to_reg, reg_write;
    logic [2:0]  alu_ctrl_sig;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, inst;
    logic        mem_req, mem_we, mem_ready, stall, timeout, zero;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_wdata;
        logic        we;
        logic        stall;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   vectors = 0, miscompares = 0;
    int   mon_vec = 0, mon_err = 0;

    mc_datapath_hs dut (
        .clk(clk), .reset(reset), .mem_step(mem_step), .mem_write(mem_write),
        .i_or_d(i_or_d), .ireg_enab(ireg_enab), .pc_enab(pc_enab), .pc_src(pc_src),
        .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_ctrl_sig(alu_ctrl_sig),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_req(mem_req), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall(stall), .timeout(timeout),
        .zero(zero), .inst(inst)
    );

    always #5 clk = ~clk;

    // Monitor: every presented request is matched against the next expected entry
    always @(negedge clk) begin
        if (mem_req) begin
            mon_vec++;
            if (sb_q.size() == 0) begin
                mon_err++;
                $display("FAIL unexpected_req addr=%h we=%b stall=%b", mem_addr, mem_we, stall);
            end else begin
                e = sb_q.pop_front();
                if (mem_addr !== e.addr || mem_we !== e.we || stall !== e.stall ||
                    (e.chk_wdata && mem_wdata !== e.wdata)) begin
                    mon_err++;
                    $display("FAIL req got addr=%h we=%b stall=%b wdata=%h exp addr=%h we=%b stall=%b wdata=%h",
                             mem_addr, mem_we, stall, mem_wdata, e.addr, e.we, e.stall, e.wdata);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic chk, input logic we, input logic st);
        exp_t x;
        x.addr = addr; x.wdata = wdata; x.chk_wdata = chk; x.we = we; x.stall = st;
        sb_q.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic idle_in();
        mem_step = 0; mem_write = 0; i_or_d = 0; ireg_enab = 0; pc_enab = 0;
        pc_src = 2'd0; alu_srcA = 0; alu_srcB = 2'd0; reg_dst = 0; mem_to_reg = 0;
        reg_write = 0; alu_ctrl_sig = ALU_AND; mem_ready = 0; mem_rdata = '0;
    endtask

    initial begin
        reset = 1; idle_in();
        step(); step();
        reset = 0;
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_timeout", 32'(timeout), 0);
        chk("rst_inst", inst, 0);
        chk("rst_pc", mem_addr, 0);
        chk("rst_zero", 32'(zero), 1);

        // zero-wait fetch
        mem_step = 1; ireg_enab = 1; mem_ready = 1; mem_rdata = 32'h2008_0005;
        push(32'h0, 32'h0, 0, 0, 0);
        chk("fetch0_stall", 32'(stall), 0);
        step(); idle_in();
        chk("fetch0_inst", inst, 32'h2008_0005);

        // three-wait fetch with pc_enab held: pc frozen, advances on completion
        mem_step = 1; ireg_enab = 1; pc_enab = 1; alu_srcB = SRCB_FOUR;
        alu_ctrl_sig = ALU_ADD; mem_rdata = 32'h2008_0040;
        for (int i = 0; i < 3; i++) begin
            push(32'h0, 32'h0, 0, 0, 1);
            step();
        end
        mem_ready = 1; push(32'h0, 32'h0, 0, 0, 0);
        step(); idle_in();
        chk("wait3_pc", mem_addr, 32'h4);
        chk("wait3_inst", inst, 32'h2008_0040);

        // load DEADBEEF and write it back into rt (reg 8), alu_out = 0 + 0x40
        mem_step = 1; mem_ready = 1; mem_rdata = 32'hDEAD_BEEF;
        push(32'h4, 32'h0, 0, 0, 0);
        step(); idle_in();
        reg_write = 1; mem_to_reg = 1; alu_srcA = 1; alu_srcB = SRCB_IMM; alu_ctrl_sig = ALU_ADD;
        step();
        reg_write = 0; mem_to_reg = 0;
        step();
        chk("b_reg", mem_wdata, 32'hDEAD_BEEF);

        // store with 2 waits; ALU now yields 4 so an ungated alu_out would move the address
        mem_step = 1; mem_write = 1; i_or_d = 1; alu_srcB = SRCB_FOUR;
        ireg_enab = 1; mem_rdata = 32'h1111_1111;
        push(32'h40, 32'hDEAD_BEEF, 1, 1, 1); step();
        push(32'h40, 32'hDEAD_BEEF, 1, 1, 1); step();
        mem_ready = 1; push(32'h40, 32'hDEAD_BEEF, 1, 1, 0);
        step(); idle_in();
        chk("store_no_ireg", inst, 32'h2008_0040);

        // build pc = 0x1000_0004 via reg 8 and the ALU
        mem_step = 1; mem_ready = 1; mem_rdata = 32'h1000_0004;
        push(32'h4, 32'h0, 0, 0, 0);
        step(); idle_in();
        reg_write = 1; mem_to_reg = 1;
        step(); idle_in();
        step();
        alu_srcA = 1; alu_srcB = SRCB_B; alu_ctrl_sig = ALU_ADD; pc_enab = 1;
        chk("alu_nonzero", 32'(zero), 0);
        step(); idle_in();
        chk("pc_from_alu", mem_addr, 32'h1000_0004);

        // fetch the jump and take it
        mem_step = 1; ireg_enab = 1; mem_ready = 1; mem_rdata = 32'h0800_0010;
        push(32'h1000_0004, 32'h0, 0, 0, 0);
        step(); idle_in();
        chk("jump_inst", inst, 32'h0800_0010);
        pc_src = PCSRC_JMP; pc_enab = 1;
        step(); idle_in();
        chk("jump_pc", mem_addr, 32'h1000_0040);

        // timeout: 15 stalled cycles is tolerated, the 16th raises the flag
        mem_step = 1;
        for (int i = 0; i < 16; i++) begin
            push(32'h1000_0040, 32'h0, 0, 0, 1);
            step();
            if (i == 14) chk("timeout_edge", 32'(timeout), 0);
        end
        chk("timeout_set", 32'(timeout), 1);
        mem_ready = 1; push(32'h1000_0040, 32'h0, 0, 0, 0);
        step(); idle_in();
        chk("timeout_done", 32'(timeout), 1);
        step(); step();
        chk("timeout_sticky", 32'(timeout), 1);
        reset = 1; step(); reset = 0;
        chk("timeout_clr", 32'(timeout), 0);
        chk("reset_pc", mem_addr, 32'h0);

        // reset during the second wait cycle drops the request
        mem_step = 1; ireg_enab = 1;
        push(32'h0, 32'h0, 0, 0, 1); step();
        push(32'h0, 32'h0, 0, 0, 1); step();
        reset = 1; step();
        reset = 0; mem_step = 0; mem_ready = 1; mem_rdata = 32'hFFFF_FFFF;
        chk("rstw_req", 32'(mem_req), 0);
        chk("rstw_stall", 32'(stall), 0);
        chk("rstw_pc", mem_addr, 32'h0);
        step(); idle_in();
        chk("rstw_inst", inst, 32'h0);

        step();
        chk("sb_drain", 32'(sb_q.size()), 0);
        vectors += mon_vec;
        miscompares += mon_err;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
